// File: rtl/data_mem_pkg.sv
// Shared encodings and lane helpers for the MIPS data memory controller.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {INIT, IDLE, WAIT, ACC, RESP} state_e;

  function automatic logic [3:0] be_mask(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_BYTE: be_mask = 4'b0001 << lane;
      SZ_HALF: be_mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be_mask = 4'b1111;
      default: be_mask = 4'b0000;
    endcase
  endfunction

  // Store data is replicated so any enabled lane already holds the right byte.
  function automatic logic [31:0] store_data(size_e sz, logic [31:0] wd);
    case (sz)
      SZ_BYTE: store_data = {4{wd[7:0]}};
      SZ_HALF: store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(size_e sz, logic sext, logic [1:0] lane,
                                           logic [31:0] q);
    logic [31:0] sh;
    sh = q >> {lane, 3'b000};
    case (sz)
      SZ_BYTE: load_ext = {{24{sext & sh[7]}}, sh[7:0]};
      SZ_HALF: load_ext = {{16{sext & sh[15]}}, sh[15:0]};
      default: load_ext = q;
    endcase
  endfunction

endpackage

// File: rtl/mem_array_be.sv
// Single-port DEPTH x 32 storage with per-byte write enables and registered read.
module mem_array_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++)
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: req/ack front end, fault screening, wait states,
// post-reset clear and little-endian lane alignment around mem_array_be.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h1001_0000,
  parameter int          DEPTH          = 1024,
  parameter int          WAIT_STATES    = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [32:0] WIN = 33'(DEPTH) << 2;

  state_e        r_state, w_next;
  logic [AW-1:0] r_ptr, r_idx;
  logic [3:0]    r_cnt;
  logic          r_we, r_sext, r_ready, r_ack, r_fault;
  size_e         r_size;
  logic [1:0]    r_lane;
  logic [31:0]   r_wdata;

  logic [31:0]   w_off, w_arr_wd, w_arr_q;
  logic [AW-1:0] w_arr_addr;
  logic [3:0]    w_arr_be;
  logic          w_bad, w_accept;
  size_e         w_size;

  assign w_size   = size_e'(i_size);
  assign w_off    = i_addr - BASE_ADDR;
  // Addresses below BASE wrap to a huge offset and fail the window test.
  assign w_bad    = ({1'b0, w_off} >= WIN) || (w_size == SZ_RSVD) ||
                    (w_size == SZ_HALF && i_addr[0]) ||
                    (w_size == SZ_WORD && i_addr[1:0] != 2'b00);
  assign w_accept = (r_state == IDLE) && i_req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT: if (r_ptr == AW'(DEPTH - 1)) w_next = IDLE;
      IDLE: if (i_req) w_next = w_bad ? RESP : (WAIT_STATES == 0 ? ACC : WAIT);
      WAIT: if (r_cnt == 4'd0) w_next = ACC;
      ACC:  w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_arr_addr = '0;
    w_arr_be   = 4'b0000;
    w_arr_wd   = '0;
    if (r_state == INIT) begin
      w_arr_addr = r_ptr;
      w_arr_be   = 4'b1111;
    end else if (r_state == ACC) begin
      w_arr_addr = r_idx;
      w_arr_be   = r_we ? be_mask(r_size, r_lane) : 4'b0000;
      w_arr_wd   = store_data(r_size, r_wdata);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLEAR_ON_RESET ? INIT : IDLE;
      r_ready <= !CLEAR_ON_RESET;
      r_ack   <= 1'b0;
      r_fault <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= SZ_BYTE;
      r_lane  <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
      r_ack   <= (w_next == RESP);
      if (r_state == INIT) r_ptr <= r_ptr + 1'b1;
      if (r_state == WAIT) r_cnt <= r_cnt - 1'b1;
      if (r_state == RESP) r_fault <= 1'b0;
      if (w_accept) begin
        r_we    <= i_we;
        r_sext  <= i_sext;
        r_size  <= w_size;
        r_lane  <= i_addr[1:0];
        r_idx   <= w_off[AW+1:2];
        r_wdata <= i_wdata;
        r_fault <= w_bad;
        r_cnt   <= 4'(WAIT_STATES - 1);
      end
    end
  end

  mem_array_be #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .i_clk   (i_clk),
    .i_addr  (w_arr_addr),
    .i_be    (w_arr_be),
    .i_wdata (w_arr_wd),
    .o_rdata (w_arr_q)
  );

  // Array output is registered at the ACC edge, so it is stable throughout RESP.
  assign o_ready = r_ready;
  assign o_ack   = r_ack;
  assign o_fault = r_ack & r_fault;
  assign o_rdata = (r_ack && !r_fault && !r_we) ?
                   load_ext(r_size, r_sext, r_lane, w_arr_q) : 32'h0;

endmodule
